// File: rtl/kl_mem_req_sched.sv
// Memory read scheduler for BWT occurrence fetches: turns one k/l request into one
// shared read or two separate reads, and tracks how many reads are still in flight.
module kl_mem_req_sched #(
   parameter int MAX_OUTSTANDING = 16,
   parameter int ADDR_W          = 42
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              request_valid,
   input  logic [ADDR_W-1:0] addr_k,
   input  logic [ADDR_W-1:0] addr_l,
   input  logic [8:0]        read_num,
   output logic              stall,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [10:0]       mem_req_tag,
   input  logic              mem_rsp_valid,
   output logic [5:0]        outstanding,
   output logic              err_underflow
);

   typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L} state_t;

   // An accept may add two reads, so admission stops two below the ceiling.
   localparam logic [5:0] OUT_GATE = 6'(MAX_OUTSTANDING - 2);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] addr_l_q;
   logic [8:0]        read_num_q;
   logic [1:0]        sel_q;
   logic              handshake;
   logic              accept;
   logic              same_line;

   assign handshake = mem_req_valid && mem_req_ready;
   assign stall     = (state != IDLE) || (outstanding > OUT_GATE);
   assign accept    = request_valid && !stall;
   assign same_line = (addr_k == addr_l);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = ISSUE_K;
         ISSUE_K: if (handshake) state_next = (sel_q == 2'b11) ? IDLE : ISSUE_L;
         ISSUE_L: if (handshake) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Payload only changes on accept or when moving K -> L, so it holds under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_tag   <= '0;
         addr_l_q      <= '0;
         read_num_q    <= '0;
         sel_q         <= 2'b00;
      end else begin
         mem_req_valid <= (state_next != IDLE);
         if (accept) begin
            addr_l_q     <= addr_l;
            read_num_q   <= read_num;
            sel_q        <= same_line ? 2'b11 : 2'b01;
            mem_req_addr <= addr_k;
            mem_req_tag  <= {read_num, (same_line ? 2'b11 : 2'b01)};
         end else if ((state == ISSUE_K) && handshake && (sel_q == 2'b01)) begin
            mem_req_addr <= addr_l_q;
            mem_req_tag  <= {read_num_q, 2'b10};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding   <= '0;
         err_underflow <= 1'b0;
      end else if (handshake && !mem_rsp_valid) begin
         outstanding <= outstanding + 6'd1;
      end else if (!handshake && mem_rsp_valid) begin
         if (outstanding == 6'd0) begin
            err_underflow <= 1'b1;
         end else begin
            outstanding <= outstanding - 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_kl_mem_req_sched.sv
// Directed and randomized check of kl_mem_req_sched against a queue-based model of
// pending memory reads and an in-flight counter.
module tb_kl_mem_req_sched;

   localparam int MAX_OUT = 4;
   localparam int ADDR_W  = 42;

   logic              clk = 1'b0;
   logic              rst;
   logic              request_valid;
   logic [ADDR_W-1:0] addr_k;
   logic [ADDR_W-1:0] addr_l;
   logic [8:0]        read_num;
   logic              stall;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [10:0]       mem_req_tag;
   logic              mem_rsp_valid;
   logic [5:0]        outstanding;
   logic              err_underflow;

   always #5 clk = ~clk;

   kl_mem_req_sched #(.MAX_OUTSTANDING(MAX_OUT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .request_valid(request_valid), .addr_k(addr_k),
      .addr_l(addr_l), .read_num(read_num), .stall(stall), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
      .mem_rsp_valid(mem_rsp_valid), .outstanding(outstanding), .err_underflow(err_underflow)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [10:0]       tag;
   } beat_t;

   beat_t pend[$];
   int    m_out;
   bit    m_err;
   bit    m_fresh;
   int    tests = 0;
   int    fails = 0;

   function automatic bit model_stall();
      return (pend.size() != 0) || (m_out > MAX_OUT - 2);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reads still to be issued live in a queue; the head is what the port must show.
   task automatic model_step();
      bit hs;
      bit acc;
      if (rst) begin
         pend.delete();
         m_out   = 0;
         m_err   = 1'b0;
         m_fresh = 1'b1;
         return;
      end
      hs  = (pend.size() != 0) && mem_req_ready;
      acc = request_valid && !model_stall();
      if (hs && !mem_rsp_valid) begin
         m_out++;
      end else if (!hs && mem_rsp_valid) begin
         if (m_out == 0) m_err = 1'b1;
         else m_out--;
      end
      if (hs) void'(pend.pop_front());
      if (acc) begin
         m_fresh = 1'b0;
         if (addr_k == addr_l) begin
            pend.push_back('{addr_k, {read_num, 2'b11}});
         end else begin
            pend.push_back('{addr_k, {read_num, 2'b01}});
            pend.push_back('{addr_l, {read_num, 2'b10}});
         end
      end
   endtask

   task automatic compare_all();
      check("valid", 64'(mem_req_valid), 64'(pend.size() != 0));
      check("stall", 64'(stall), 64'(model_stall()));
      check("outstanding", 64'(outstanding), 64'(m_out));
      check("err_underflow", 64'(err_underflow), 64'(m_err));
      if (pend.size() != 0) begin
         check("addr", 64'(mem_req_addr), 64'(pend[0].addr));
         check("tag", 64'(mem_req_tag), 64'(pend[0].tag));
      end else if (m_fresh) begin
         check("addr_reset", 64'(mem_req_addr), 64'd0);
         check("tag_reset", 64'(mem_req_tag), 64'd0);
      end
   endtask

   task automatic applyStimulus(input logic rv, input logic [ADDR_W-1:0] ak,
                                input logic [ADDR_W-1:0] al, input logic [8:0] rn,
                                input logic rdy, input logic rsp);
      request_valid = rv;
      addr_k        = ak;
      addr_l        = al;
      read_num      = rn;
      mem_req_ready = rdy;
      mem_rsp_valid = rsp;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin : main
      logic [ADDR_W-1:0] ak;
      logic [ADDR_W-1:0] al;

      rst = 1'b1;
      applyStimulus(1'b1, 42'h55, 42'h66, 9'd1, 1'b1, 1'b0);
      tick();
      check("rst_override_valid", 64'(mem_req_valid), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      rst = 1'b0;

      // Split request: K then L on consecutive cycles.
      applyStimulus(1'b1, 42'h100, 42'h200, 9'd5, 1'b1, 1'b0);
      tick();
      check("split_k_tag", 64'(mem_req_tag), 64'h015);
      check("split_k_addr", 64'(mem_req_addr), 64'h100);
      check("split_k_stall", 64'(stall), 64'd1);
      request_valid = 1'b0;
      tick();
      check("split_l_tag", 64'(mem_req_tag), 64'h016);
      check("split_l_addr", 64'(mem_req_addr), 64'h200);
      check("split_l_stall", 64'(stall), 64'd1);
      tick();
      check("split_out", 64'(outstanding), 64'd2);
      check("split_idle_valid", 64'(mem_req_valid), 64'd0);

      // Shared line: a single request.
      rst = 1'b1; tick(); rst = 1'b0;
      applyStimulus(1'b1, 42'h340, 42'h340, 9'd3, 1'b1, 1'b0);
      tick();
      check("shared_tag", 64'(mem_req_tag), 64'h00F);
      check("shared_addr", 64'(mem_req_addr), 64'h340);
      request_valid = 1'b0;
      tick();
      check("shared_idle", 64'(mem_req_valid), 64'd0);
      check("shared_out", 64'(outstanding), 64'd1);

      // Backpressure during K.
      rst = 1'b1; tick(); rst = 1'b0;
      applyStimulus(1'b1, 42'h111, 42'h222, 9'd7, 1'b0, 1'b0);
      tick();
      request_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_tag", 64'(mem_req_tag), 64'h01D);
         check("bp_addr", 64'(mem_req_addr), 64'h111);
         check("bp_stall", 64'(stall), 64'd1);
      end
      mem_req_ready = 1'b1;
      tick();
      check("bp_l_tag", 64'(mem_req_tag), 64'h01E);
      tick();
      check("bp_out", 64'(outstanding), 64'd2);

      // Outstanding gate with a held request and no responses.
      rst = 1'b1; tick(); rst = 1'b0;
      applyStimulus(1'b1, 42'h10, 42'h20, 9'd1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) tick();
      check("gate_out", 64'(outstanding), 64'd4);
      check("gate_stall", 64'(stall), 64'd1);
      mem_rsp_valid = 1'b1;
      tick();
      check("gate_out_3", 64'(outstanding), 64'd3);
      check("gate_stall_3", 64'(stall), 64'd1);
      tick();
      check("gate_out_2", 64'(outstanding), 64'd2);
      check("gate_stall_low", 64'(stall), 64'd0);
      applyStimulus(1'b0, 42'h0, 42'h0, 9'd0, 1'b1, 1'b0);

      // Simultaneous handshake and response, then underflow.
      rst = 1'b1; tick(); rst = 1'b0;
      applyStimulus(1'b1, 42'h30, 42'h40, 9'd2, 1'b1, 1'b0);
      tick(); request_valid = 1'b0; tick(); tick();
      request_valid = 1'b1;
      tick();
      request_valid = 1'b0;
      mem_rsp_valid = 1'b1;
      tick();
      check("simul_out", 64'(outstanding), 64'd2);
      mem_rsp_valid = 1'b0;
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      mem_rsp_valid = 1'b1;
      tick();
      check("underflow_set", 64'(err_underflow), 64'd1);
      check("underflow_out", 64'(outstanding), 64'd0);
      mem_rsp_valid = 1'b0;
      tick(); tick();
      check("underflow_sticky", 64'(err_underflow), 64'd1);

      // Reset while L is pending; a late response then underflows.
      rst = 1'b1; tick(); rst = 1'b0;
      applyStimulus(1'b1, 42'h50, 42'h60, 9'd9, 1'b1, 1'b0);
      tick(); request_valid = 1'b0; tick();
      check("abort_out_before", 64'(outstanding), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_valid", 64'(mem_req_valid), 64'd0);
      check("abort_out", 64'(outstanding), 64'd0);
      check("abort_stall", 64'(stall), 64'd0);
      mem_rsp_valid = 1'b1;
      tick();
      check("late_rsp_underflow", 64'(err_underflow), 64'd1);

      for (int i = 0; i < 800; i++) begin
         ak = ADDR_W'($urandom_range(0, 7)) << 6;
         al = ($urandom_range(0, 3) == 0) ? ak : (ADDR_W'($urandom_range(0, 7)) << 6) + 42'h20;
         rst = ($urandom_range(0, 99) == 0);
         applyStimulus(1'($urandom_range(0, 1)), ak, al, 9'($urandom),
                       ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/kl_mem_req_sched.md
KL_MEM_REQ_SCHED -- requirements
Module: kl_mem_req_sched

Interface
REQ-001 Parameter MAX_OUTSTANDING, 16: maximum memory reads in flight, range 2..63.
REQ-002 Parameter ADDR_W, 42: memory address width.
REQ-003 clk  input  1: single clock; all logic on rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 request_valid  input  1: BWT occurrence-fetch request from the k/l calculation stage.
REQ-006 addr_k  input  ADDR_W: k-side line address.
REQ-007 addr_l  input  ADDR_W: l-side line address.
REQ-008 read_num  input  9: read identifier of the request.
REQ-009 stall  output  1: backpressure to the k/l stage; the stage holds its outputs while high.
REQ-010 mem_req_valid  output  1: memory read request valid.
REQ-011 mem_req_ready  input  1: memory port accepts the request when valid and ready are both high.
REQ-012 mem_req_addr  output  ADDR_W: memory read address.
REQ-013 mem_req_tag  output  11: {read_num, sel[1:0]}; sel 01 = k, 10 = l, 11 = k and l shared.
REQ-014 mem_rsp_valid  input  1: one memory response returned; pulse per response.
REQ-015 outstanding  output  6: reads currently in flight.
REQ-016 err_underflow  output  1: sticky flag, response received with outstanding == 0.

Function
REQ-017 The FSM shall have states IDLE, ISSUE_K, ISSUE_L.
REQ-018 stall shall be combinational: high when state != IDLE or outstanding > MAX_OUTSTANDING-2; otherwise low.
REQ-019 A request is accepted in a cycle where request_valid=1 and stall=0; addr_k, addr_l and read_num are captured that cycle.
REQ-020 On accept with addr_k == addr_l, the FSM shall go to ISSUE_K with sel latched as 11, and ISSUE_L is skipped.
REQ-021 On accept with addr_k != addr_l, the FSM shall go to ISSUE_K with sel 01, then to ISSUE_L with sel 10.
REQ-022 mem_req_valid, mem_req_addr and mem_req_tag shall be registered; mem_req_valid is high exactly while in ISSUE_K or ISSUE_L.
REQ-023 Payload shall remain stable while mem_req_valid=1 and mem_req_ready=0.
REQ-024 Handshake in ISSUE_K shall move the FSM to ISSUE_L (sel 01) or to IDLE (sel 11).
REQ-025 Handshake in ISSUE_L shall move the FSM to IDLE.
REQ-026 Latency: accept in cycle N gives the earliest K request in cycle N+1 and the earliest L request in N+2; the next accept is possible in N+3.
REQ-027 outstanding shall increment by 1 per memory handshake and decrement by 1 per mem_rsp_valid.
REQ-028 A simultaneous handshake and response shall leave outstanding unchanged.
REQ-029 mem_rsp_valid with outstanding == 0 (and no simultaneous handshake) shall set err_underflow and leave outstanding at 0.
REQ-030 The outstanding-gate in REQ-018 shall guarantee that outstanding never exceeds MAX_OUTSTANDING.
REQ-031 A request with request_valid=0 shall be ignored; a held request_valid during stall shall not create a duplicate accept.

Reset
REQ-032 In the cycle after rst=1 the block shall have: state=IDLE, mem_req_valid=0, mem_req_addr=0, mem_req_tag=0, outstanding=0, err_underflow=0, stall=0.
REQ-033 rst asserted mid-issue shall abort pending K/L requests without a handshake; any in-flight responses arriving after reset shall count toward underflow.
REQ-034 rst shall override every other input in the same cycle.

Verification
REQ-035 Single request, addr_k=0x100, addr_l=0x200, read_num=5, ready=1 -> tag 0x015 at addr 0x100 in N+1, tag 0x016 at addr 0x200 in N+2, stall high N+1..N+2, outstanding=2.
REQ-036 addr_k=addr_l=0x340, read_num=3 -> one request with tag 0x00F, FSM back to IDLE after 1 handshake, outstanding=1.
REQ-037 ready=0 for 4 cycles in ISSUE_K -> address/tag held constant, stall held high, no L issued until the K handshake.
REQ-038 MAX_OUTSTANDING=4, no responses, back-to-back requests -> 2 accepted (outstanding=4), stall stays high; one response -> outstanding=3, stall stays high; second response -> stall low.
REQ-039 Handshake and mem_rsp_valid in the same cycle with outstanding=2 -> outstanding stays 2; a response with outstanding=0 -> err_underflow=1, sticky until rst.
REQ-040 rst=1 during ISSUE_L with outstanding=1 -> next cycle mem_req_valid=0, outstanding=0, stall=0, state IDLE.
